// File: rtl/l2_mem_responder_2port.sv
// L2-side responder serving the I-cache (client 0) and D-cache (client 1) miss handlers with a fixed-latency word array.
// Optional build macro L2_RESP_PERF_CNT_EN adds rd_cnt_o/wr_cnt_o completed-grant counters.
module l2_mem_responder_2port #(
   parameter int ADDR_W     = 10,
   parameter int ACCESS_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c0_l2_mem_en,
   input  logic        c0_l2_mem_wr_en,
   input  logic [31:0] c0_l2_mem_access_addr,
   input  logic [31:0] c0_l2_mem_wr_data,
   input  logic        c1_l2_mem_en,
   input  logic        c1_l2_mem_wr_en,
   input  logic [31:0] c1_l2_mem_access_addr,
   input  logic [31:0] c1_l2_mem_wr_data,
   output logic        c0_l2_bus_arbiter_rd_granted,
   output logic        c0_l2_bus_arbiter_wr_granted,
   output logic        c1_l2_bus_arbiter_rd_granted,
   output logic        c1_l2_bus_arbiter_wr_granted,
   output logic [31:0] l2_mem_rd_data,
   output logic        busy
`ifdef L2_RESP_PERF_CNT_EN
   ,
   output logic [15:0] rd_cnt_o,
   output logic [15:0] wr_cnt_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

   state_t              state;
   state_t              next_state;
   logic [3:0]          cnt;
   logic                rr_last;
   logic                own_id;
   logic                own_wr;
   logic [ADDR_W-1:0]   own_idx;
   logic [31:0]         own_data;
   logic                any_en;
   logic                pick;
   logic                own_en;
   logic [31:0]         mem [0:(2**ADDR_W)-1];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{c0_l2_mem_access_addr[31:ADDR_W+2], c0_l2_mem_access_addr[1:0],
                               c1_l2_mem_access_addr[31:ADDR_W+2], c1_l2_mem_access_addr[1:0]};

   // On a tie the client that did not win last time is chosen.
   assign any_en = c0_l2_mem_en | c1_l2_mem_en;
   assign pick   = (c0_l2_mem_en && c1_l2_mem_en) ? ~rr_last : c1_l2_mem_en;
   assign own_en = own_id ? c1_l2_mem_en : c0_l2_mem_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (any_en) next_state = S_WAIT;
         S_WAIT: begin
            if (!own_en)        next_state = S_IDLE;
            else if (cnt == 4'd1) next_state = S_GRANT;
         end
         S_GRANT: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy                         = (state != S_IDLE);
      c0_l2_bus_arbiter_rd_granted = (state == S_GRANT) && !own_id && !own_wr;
      c0_l2_bus_arbiter_wr_granted = (state == S_GRANT) && !own_id &&  own_wr;
      c1_l2_bus_arbiter_rd_granted = (state == S_GRANT) &&  own_id && !own_wr;
      c1_l2_bus_arbiter_wr_granted = (state == S_GRANT) &&  own_id &&  own_wr;
   end

   // Read data is captured on the edge entering GRANT so it is already valid in the grant cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= 4'd0;
         rr_last        <= 1'b1;
         own_id         <= 1'b0;
         own_wr         <= 1'b0;
         own_idx        <= '0;
         own_data       <= 32'd0;
         l2_mem_rd_data <= 32'd0;
      end else begin
         if (state == S_IDLE && any_en) begin
            own_id   <= pick;
            rr_last  <= pick;
            own_wr   <= pick ? c1_l2_mem_wr_en : c0_l2_mem_wr_en;
            own_idx  <= pick ? c1_l2_mem_access_addr[ADDR_W+1:2] : c0_l2_mem_access_addr[ADDR_W+1:2];
            own_data <= pick ? c1_l2_mem_wr_data : c0_l2_mem_wr_data;
            cnt      <= 4'(ACCESS_LAT);
         end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (state == S_WAIT && next_state == S_GRANT && !own_wr)
            l2_mem_rd_data <= mem[own_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_GRANT && own_wr) mem[own_idx] <= own_data;
   end

`ifdef L2_RESP_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_o <= 16'd0;
         wr_cnt_o <= 16'd0;
      end else if (state == S_GRANT) begin
         if (own_wr) wr_cnt_o <= wr_cnt_o + 16'd1;
         else        rd_cnt_o <= rd_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_mem_responder_2port.sv
// Randomized self-checking bench for l2_mem_responder_2port against a transaction-level model.
module tb_l2_mem_responder_2port;
   localparam int ADDR_W = 10;
   localparam int LAT    = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c0_en, c0_wr, c1_en, c1_wr;
   logic [31:0] c0_addr, c0_data, c1_addr, c1_data;
   logic        c0_rd_g, c0_wr_g, c1_rd_g, c1_wr_g;
   logic [31:0] rd_data;
   logic        busy;
`ifdef L2_RESP_PERF_CNT_EN
   logic [15:0] rd_cnt, wr_cnt;
`endif

   always #5 clk = ~clk;

   l2_mem_responder_2port #(.ADDR_W(ADDR_W), .ACCESS_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_l2_mem_en(c0_en), .c0_l2_mem_wr_en(c0_wr),
      .c0_l2_mem_access_addr(c0_addr), .c0_l2_mem_wr_data(c0_data),
      .c1_l2_mem_en(c1_en), .c1_l2_mem_wr_en(c1_wr),
      .c1_l2_mem_access_addr(c1_addr), .c1_l2_mem_wr_data(c1_data),
      .c0_l2_bus_arbiter_rd_granted(c0_rd_g), .c0_l2_bus_arbiter_wr_granted(c0_wr_g),
      .c1_l2_bus_arbiter_rd_granted(c1_rd_g), .c1_l2_bus_arbiter_wr_granted(c1_wr_g),
      .l2_mem_rd_data(rd_data), .busy(busy)
`ifdef L2_RESP_PERF_CNT_EN
      , .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [int];
   bit          rr_last = 1'b1;
   logic [31:0] last_rd = 32'd0;
   int          rd_done = 0;
   int          wr_done = 0;
   int          idx_set [8] = '{4, 16, 32, 0, 1, 2, 511, 1023};

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] grantsNow();
      return {c1_wr_g, c1_rd_g, c0_wr_g, c0_rd_g};
   endfunction

   function automatic int idxOf(input logic [31:0] addr);
      return int'((addr >> 2) & ((1 << ADDR_W) - 1));
   endfunction

   function automatic logic [31:0] mkAddr(input int idx);
      return ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
   endfunction

   task automatic applyStimulus(input int c, input bit en, input bit wr,
                                input logic [31:0] addr, input logic [31:0] data);
      if (c == 0) begin
         c0_en = en; c0_wr = wr; c0_addr = addr; c0_data = data;
      end else begin
         c1_en = en; c1_wr = wr; c1_addr = addr; c1_data = data;
      end
   endtask

   // Called at the negedge of the accept cycle; returns at the negedge of the grant cycle with en dropped.
   task automatic serveTxn(input int c, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      logic [3:0] exp_g;
      for (int i = 1; i <= LAT + 1; i++) begin
         @(negedge clk);
         checkOutput("busy_active", 32'(busy), 32'd1);
         exp_g = (i == LAT + 1) ? (4'b0001 << (2 * c + int'(wr))) : 4'b0000;
         checkOutput("grants", 32'(grantsNow()), 32'(exp_g));
      end
      if (wr) begin
         checkOutput("rd_data_hold", rd_data, last_rd);
         model_mem[idxOf(addr)] = data;
         wr_done++;
      end else begin
         last_rd = model_mem.exists(idxOf(addr)) ? model_mem[idxOf(addr)] : 32'hx;
         checkOutput("rd_data", rd_data, last_rd);
         rd_done++;
      end
      applyStimulus(c, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic singleTxn(input int c, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      applyStimulus(c, 1'b1, wr, addr, data);
      serveTxn(c, wr, addr, data);
      rr_last = c[0];
      @(negedge clk);
      checkOutput("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic pairTxn(input bit wr0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit wr1, input logic [31:0] a1, input logic [31:0] d1);
      int first;
      first = rr_last ? 0 : 1;
      applyStimulus(0, 1'b1, wr0, a0, d0);
      applyStimulus(1, 1'b1, wr1, a1, d1);
      if (first == 0) serveTxn(0, wr0, a0, d0);
      else            serveTxn(1, wr1, a1, d1);
      rr_last = first[0];
      @(negedge clk);
      checkOutput("busy_between", 32'(busy), 32'd0);
      if (first == 0) serveTxn(1, wr1, a1, d1);
      else            serveTxn(0, wr0, a0, d0);
      rr_last = ~first[0];
      @(negedge clk);
      checkOutput("busy_idle", 32'(busy), 32'd0);
   endtask

   // Owner drops en after k WAIT cycles; optionally the other client queues a read at that point.
   task automatic abortTxn(input int c, input bit wr, input logic [31:0] addr, input int k,
                           input bit other_pending, input logic [31:0] other_addr);
      applyStimulus(c, 1'b1, wr, addr, $urandom);
      for (int i = 1; i <= k; i++) begin
         @(negedge clk);
         checkOutput("abort_busy", 32'(busy), 32'd1);
         checkOutput("abort_grants", 32'(grantsNow()), 32'd0);
      end
      applyStimulus(c, 1'b0, 1'b0, 32'd0, 32'd0);
      if (other_pending) applyStimulus(1 - c, 1'b1, 1'b0, other_addr, 32'd0);
      rr_last = c[0];
      @(negedge clk);
      checkOutput("abort_idle", 32'(busy), 32'd0);
      checkOutput("abort_nogrant", 32'(grantsNow()), 32'd0);
      if (other_pending) begin
         serveTxn(1 - c, 1'b0, other_addr, 32'd0);
         rr_last = ~c[0];
         @(negedge clk);
         checkOutput("busy_idle", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int op, c, k;
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_grants", 32'(grantsNow()), 32'd0);
      checkOutput("reset_rd_data", rd_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         singleTxn(i % 2, 1'b1, mkAddr(idx_set[i]), $urandom);
      singleTxn(0, 1'b1, 32'h0000_0010, 32'h0000_0001);

      singleTxn(0, 1'b0, 32'h0000_0040, 32'd0);
      singleTxn(1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF);
      singleTxn(0, 1'b0, 32'h0000_0080, 32'd0);

      rr_last = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      last_rd = 32'd0;
      rd_done = 0;
      wr_done = 0;
      pairTxn(1'b0, 32'h0000_0040, 32'd0, 1'b1, mkAddr(2), 32'h1234_5678);
      pairTxn(1'b1, mkAddr(1), 32'hCAFE_F00D, 1'b0, mkAddr(1), 32'd0);

      abortTxn(0, 1'b0, 32'h0000_0040, 2, 1'b1, 32'h0000_0080);

      applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_grants", 32'(grantsNow()), 32'd0);
      checkOutput("rst_mid_rd_data", rd_data, 32'd0);
      @(negedge clk);
      checkOutput("rst_hold_grants", 32'(grantsNow()), 32'd0);
      rst_n = 1'b1;
      rr_last = 1'b1;
      last_rd = 32'd0;
      rd_done = 0;
      wr_done = 0;
      @(negedge clk);
      singleTxn(1, 1'b0, 32'h0000_0010, 32'd0);

      for (int n = 0; n < 40; n++) begin
         op = $urandom_range(0, 3);
         c  = $urandom_range(0, 1);
         if (op == 0)
            abortTxn(c, 1'($urandom), mkAddr(idx_set[$urandom_range(0, 7)]), $urandom_range(1, LAT),
                     1'($urandom), mkAddr(idx_set[$urandom_range(0, 7)]));
         else if (op == 1)
            pairTxn(1'($urandom), mkAddr(idx_set[$urandom_range(0, 7)]), $urandom,
                    1'($urandom), mkAddr(idx_set[$urandom_range(0, 7)]), $urandom);
         else
            singleTxn(c, 1'($urandom), mkAddr(idx_set[$urandom_range(0, 7)]), $urandom);
      end

`ifdef L2_RESP_PERF_CNT_EN
      checkOutput("rd_cnt", 32'(rd_cnt), 32'(rd_done & 16'hFFFF));
      checkOutput("wr_cnt", 32'(wr_cnt), 32'(wr_done & 16'hFFFF));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Grants must be one-hot or zero in every cycle.
   always @(negedge clk) begin
      if (rst_n && !$onehot0(grantsNow())) begin
         checks++;
         errors++;
         $display("[TB] FAIL grant_onehot: got %b expected at most one bit", grantsNow());
      end
   end
endmodule
